// File: rtl/retire_if.sv
// retire_if: writeback/retire bus from the core plus the status returned by retire_monitor.
interface retire_if;
  logic        wb_valid;
  logic        wb_is_halt;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        mem_busy;
  logic        halt_out;
  logic [15:0] ret_val;
  logic        timeout;
  logic        late_retire;
  logic [31:0] retired_count;
  modport master (
    output wb_valid, wb_is_halt, wb_we, wb_rd, wb_data, mem_busy,
    input  halt_out, ret_val, timeout, late_retire, retired_count
  );
  modport slave (
    input  wb_valid, wb_is_halt, wb_we, wb_rd, wb_data, mem_busy,
    output halt_out, ret_val, timeout, late_retire, retired_count
  );
endinterface

// File: rtl/retire_monitor.sv
// retire_monitor: tracks retirement, captures the return register and sequences halt through a store drain.
// Define RETIRE_COUNT_EN to build the saturating retired_count register; otherwise it reads 0.
module retire_monitor #(
  parameter int RET_REG   = 3,
  parameter int DRAIN_MAX = 1024
) (
  input logic     clk,
  input logic     rst,
  retire_if.slave bus
);
  localparam int DW = $clog2(DRAIN_MAX) + 1;
  localparam logic RET_EN = RET_REG != 0;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t        state_q;
  logic [DW-1:0] drain_q;
  logic [1:0]    idle_q;
  logic [15:0]   ret_q;
  logic          to_q;
  logic          late_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      idle_q  <= '0;
      ret_q   <= '0;
      to_q    <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      late_q <= late_q | (bus.wb_valid && state_q != RUN);
      case (state_q)
        RUN:
          if (bus.wb_valid) begin
            if (bus.wb_is_halt) begin
              state_q <= DRAIN;
              drain_q <= '0;
              idle_q  <= '0;
            end else if (RET_EN && bus.wb_we && bus.wb_rd == 3'(RET_REG))
              ret_q <= bus.wb_data;
          end
        DRAIN: begin
          // two idle cycles already seen wins over a simultaneous drain limit
          if (idle_q == 2'd2)
            state_q <= HALTED;
          else if (drain_q == DW'(DRAIN_MAX - 1)) begin
            state_q <= HALTED;
            to_q    <= 1'b1;
          end
          drain_q <= drain_q + 1'b1;
          idle_q  <= bus.mem_busy ? 2'd0 : idle_q + 2'd1;
        end
        default: ;
      endcase
    end
  assign bus.halt_out    = state_q == HALTED;
  assign bus.ret_val     = ret_q;
  assign bus.timeout     = to_q;
  assign bus.late_retire = late_q;
`ifdef RETIRE_COUNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      cnt_q <= '0;
    else if (state_q == RUN && bus.wb_valid && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  assign bus.retired_count = cnt_q;
`else
  assign bus.retired_count = '0;
`endif
endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: random retire programs with a scoreboard checked at each halt_out rise.
`timescale 1ns/1ps
module tb_retire_monitor;
  localparam int DM = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  retire_if bus();
  retire_monitor #(.RET_REG(3), .DRAIN_MAX(DM)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int          edge_n;
    logic [15:0] rv;
    logic        to;
    logic        late;
    logic [31:0] cnt;
  } exp_t;
  exp_t        exp_q[$];
  logic [20:0] prog[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          ncyc = 0;
  logic        prev_halt = 1'b0;
  always @(posedge clk) ncyc <= ncyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ecnt(input int c);
`ifdef RETIRE_COUNT_EN
    return 32'(c);
`else
    return 32'(c * 0);
`endif
  endfunction
  always @(negedge clk) begin
    if (bus.halt_out && !prev_halt) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_halt: halt_out=1 at cycle %0d, required 0", ncyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("halt_edge", 32'(ncyc), 32'(e.edge_n));
        chk("ret_val", {16'h0, bus.ret_val}, {16'h0, e.rv});
        chk("timeout", {31'h0, bus.timeout}, {31'h0, e.to});
        chk("late_retire", {31'h0, bus.late_retire}, {31'h0, e.late});
        chk("retired_count", bus.retired_count, e.cnt);
      end
    end
    prev_halt = bus.halt_out;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    bus.wb_valid = 1'b0;
    bus.wb_is_halt = 1'b0;
    bus.wb_we = 1'b0;
    bus.wb_rd = 3'd0;
    bus.wb_data = 16'h0;
    bus.mem_busy = 1'b0;
  endtask
  task automatic do_reset;
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic exec(input bit halt_we, input int nbusy, input bit rnd);
    logic [15:0] rv;
    int cnt, j, he, h;
    bit late;
    bit m[DM+2];
    bit p[DM+2];
    rv = 16'h0; cnt = 0; j = 1 << 20; late = 1'b0;
    do_reset();
    chk("rst_halt_out", {31'h0, bus.halt_out}, 32'h0);
    chk("rst_ret_val", {16'h0, bus.ret_val}, 32'h0);
    chk("rst_timeout", {31'h0, bus.timeout}, 32'h0);
    foreach (prog[i]) begin
      {bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data} = prog[i];
      if (prog[i][20]) begin
        cnt++;
        if (prog[i][19] && prog[i][18:16] == 3'd3) rv = prog[i][15:0];
      end
      tick();
    end
    bus.wb_valid = 1'b1; bus.wb_is_halt = 1'b1; bus.wb_we = halt_we; bus.wb_rd = 3'd3; bus.wb_data = 16'h7;
    cnt++;
    for (int k = 0; k < DM + 2; k++) begin
      m[k] = k < nbusy || (rnd && $urandom_range(0, 3) == 0);
      p[k] = rnd && $urandom_range(0, 7) == 0;
    end
    // halt edge index (after acceptance) where two consecutive idle drain cycles complete
    for (int k = 1; k < DM + 2; k++)
      if (!m[k-1] && !m[k] && j > k + 2) j = k + 2;
    he = j <= DM ? j : DM;
    for (int k = 0; k < he; k++) late |= p[k];
    h = ncyc + 1;
    exp_q.push_back('{h + he, rv, j > DM, late, ecnt(cnt)});
    tick();
    bus.wb_is_halt = 1'b0;
    for (int k = 0; k < he; k++) begin
      bus.wb_valid = p[k]; bus.wb_we = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 16'($urandom);
      bus.mem_busy = m[k];
      tick();
    end
    idle_in();
    tick();
    tick();
    chk("halt_seen_pending", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    bus.wb_valid = 1'b1; bus.wb_we = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 16'hBEEF;
    tick();
    idle_in();
    chk("halted_late", {31'h0, bus.late_retire}, 32'h1);
    chk("halted_ret_val", {16'h0, bus.ret_val}, {16'h0, rv});
    chk("halted_count", bus.retired_count, ecnt(cnt));
    chk("halted_hold", {31'h0, bus.halt_out}, 32'h1);
  endtask
  task automatic abort_test;
    int cnt;
    cnt = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_we = i == 99 ? 1'b1 : 1'($urandom);
      bus.wb_rd = i == 99 ? 3'd3 : 3'($urandom);
      bus.wb_data = i == 99 ? 16'h55AA : 16'($urandom);
      cnt++;
      tick();
    end
    bus.wb_is_halt = 1'b1; bus.wb_we = 1'b0;
    cnt++;
    tick();
    bus.wb_is_halt = 1'b0; bus.mem_busy = 1'b1;
    tick();
    bus.wb_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_count", bus.retired_count, ecnt(cnt));
    chk("pre_rst_ret_val", {16'h0, bus.ret_val}, 32'h55AA);
    chk("pre_rst_late", {31'h0, bus.late_retire}, 32'h1);
    chk("pre_rst_halt_out", {31'h0, bus.halt_out}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ret_val", {16'h0, bus.ret_val}, 32'h0);
    chk("async_rst_late", {31'h0, bus.late_retire}, 32'h0);
    chk("async_rst_count", bus.retired_count, 32'h0);
    chk("async_rst_timeout", {31'h0, bus.timeout}, 32'h0);
    tick();
    rst = 1'b0;
    bus.mem_busy = 1'b0;
    repeat (5) tick();
    chk("post_rst_run", {31'h0, bus.halt_out}, 32'h0);
  endtask
  initial begin
    idle_in();
    prog.push_back({1'b1, 1'b1, 3'd3, 16'h002A});
    exec(1'b0, 0, 1'b0);
    exec(1'b0, 10, 1'b0);
    exec(1'b0, 100, 1'b0);
    prog.delete();
    prog.push_back({1'b1, 1'b1, 3'd0, 16'h0005});
    exec(1'b1, 0, 1'b0);
    for (int t = 0; t < 24; t++) begin
      prog.delete();
      repeat ($urandom_range(0, 12))
        prog.push_back({$urandom_range(0, 3) != 0, 1'($urandom),
                        ($urandom_range(0, 1) == 1 ? 3'd3 : 3'($urandom)), 16'($urandom)});
      exec(1'($urandom), $urandom_range(0, 20), 1'b1);
    end
    abort_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
